// File: rtl/rib_arbiter_if.sv
// Signal bundle between the two rib masters, the arbiter and the rib bus.
// "slave" is the arbiter's view; "master" is the view of the requesters plus the bus side.
interface rib_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_lock;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_lock;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt;
    logic [DW-1:0] m1_rdata;

    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata;

    logic          owner;
    logic          busy;
    logic          timeout_err;

    modport slave (
        input  m0_req, m0_lock, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_lock, m1_we, m1_addr, m1_wdata,
        input  bus_rdata,
        output m0_gnt, m0_rdata, m1_gnt, m1_rdata,
        output bus_we, bus_addr, bus_wdata,
        output owner, busy, timeout_err
    );

    modport master (
        output m0_req, m0_lock, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_lock, m1_we, m1_addr, m1_wdata,
        output bus_rdata,
        input  m0_gnt, m0_rdata, m1_gnt, m1_rdata,
        input  bus_we, bus_addr, bus_wdata,
        input  owner, busy, timeout_err
    );
endinterface

// File: rtl/rib_arbiter.sv
// Two-master round-robin rib arbiter with bus lock; grant is 1 cycle after request, owner muxed onto rib.
// RIB_ARB_TIMEOUT_EN: bounds a locked hold to MAX_HOLD cycles when the other master is waiting.
module rib_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    rib_arbiter_if.slave  io_rib
);
    typedef enum logic [1:0] {S_IDLE, S_GNT0, S_GNT1} state_t;

    state_t r_state;
    state_t w_next;
    state_t w_other;
    logic   r_last_owner;
    logic   w_own_req;
    logic   w_own_lock;
    logic   w_oth_req;

    assign w_own_req  = (r_state == S_GNT1) ? io_rib.m1_req  : io_rib.m0_req;
    assign w_own_lock = (r_state == S_GNT1) ? io_rib.m1_lock : io_rib.m0_lock;
    assign w_oth_req  = (r_state == S_GNT1) ? io_rib.m0_req  : io_rib.m1_req;
    assign w_other    = (r_state == S_GNT1) ? S_GNT0 : S_GNT1;

`ifdef RIB_ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_TOP = HW'(MAX_HOLD - 1);

    logic [HW-1:0] r_hold_cnt;
    logic          r_timeout_err;
    logic          w_force;

    // Lock is overridden only when the hold has run out and someone is actually waiting.
    assign w_force = (r_state != S_IDLE) && w_own_req && w_own_lock && w_oth_req
                     && (r_hold_cnt == HOLD_TOP);
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (io_rib.m0_req && io_rib.m1_req)
                    w_next = r_last_owner ? S_GNT0 : S_GNT1;
                else if (io_rib.m0_req)
                    w_next = S_GNT0;
                else if (io_rib.m1_req)
                    w_next = S_GNT1;
            end
            S_GNT0, S_GNT1: begin
                if (!w_own_req)
                    w_next = w_oth_req ? w_other : S_IDLE;
                else if (w_own_lock) begin
`ifdef RIB_ARB_TIMEOUT_EN
                    w_next = w_force ? w_other : r_state;
`else
                    w_next = r_state;
`endif
                end else if (w_oth_req)
                    w_next = w_other;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_last_owner <= 1'b1;
        end else begin
            r_state <= w_next;
            if (w_next == S_GNT0)
                r_last_owner <= 1'b0;
            else if (w_next == S_GNT1)
                r_last_owner <= 1'b1;
        end
    end

`ifdef RIB_ARB_TIMEOUT_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hold_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_force;
            if ((r_state != S_IDLE) && w_own_req && w_own_lock && (w_next == r_state))
                r_hold_cnt <= (r_hold_cnt == HOLD_TOP) ? r_hold_cnt : r_hold_cnt + 1'b1;
            else
                r_hold_cnt <= '0;
        end
    end
    assign io_rib.timeout_err = r_timeout_err;
`else
    assign io_rib.timeout_err = 1'b0;
`endif

    always_comb begin
        io_rib.bus_we    = 1'b0;
        io_rib.bus_addr  = '0;
        io_rib.bus_wdata = '0;
        case (r_state)
            S_GNT0: begin
                io_rib.bus_we    = io_rib.m0_we & io_rib.m0_req;
                io_rib.bus_addr  = io_rib.m0_addr;
                io_rib.bus_wdata = io_rib.m0_wdata;
            end
            S_GNT1: begin
                io_rib.bus_we    = io_rib.m1_we & io_rib.m1_req;
                io_rib.bus_addr  = io_rib.m1_addr;
                io_rib.bus_wdata = io_rib.m1_wdata;
            end
            default: ;
        endcase
    end

    assign io_rib.m0_gnt   = (r_state == S_GNT0);
    assign io_rib.m1_gnt   = (r_state == S_GNT1);
    assign io_rib.busy     = (r_state != S_IDLE);
    assign io_rib.owner    = (r_state == S_GNT1);
    assign io_rib.m0_rdata = io_rib.bus_rdata;
    assign io_rib.m1_rdata = io_rib.bus_rdata;
endmodule

// File: tb/tb_rib_arbiter.sv
// Directed and random checks of rib_arbiter against a cycle-level owner/hold model.
module tb_rib_arbiter;
    localparam int MAXH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    // Model state: owner id (-1 idle), last granted id, locked-cycle count, pending error pulse
    int   m_own  = -1;
    int   m_last = 1;
    int   m_hold = 0;
    bit   m_terr = 1'b0;

    rib_arbiter_if #(.AW(32), .DW(32)) rif ();

    rib_arbiter #(.AW(32), .DW(32), .MAX_HOLD(MAXH)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_rib(rif)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        rif.m0_req = 0; rif.m0_lock = 0; rif.m0_we = 0; rif.m0_addr = 0; rif.m0_wdata = 0;
        rif.m1_req = 0; rif.m1_lock = 0; rif.m1_we = 0; rif.m1_addr = 0; rif.m1_wdata = 0;
        rif.bus_rdata = 0;
    endtask

    task automatic model_reset();
        m_own = -1; m_last = 1; m_hold = 0; m_terr = 1'b0;
    endtask

    // Let combinational outputs settle, then compare everything against the model
    task automatic settle();
        logic        we_e;
        logic [31:0] a_e, d_e;
        #1;
        we_e = 0; a_e = 0; d_e = 0;
        if (m_own == 0) begin we_e = rif.m0_we & rif.m0_req; a_e = rif.m0_addr; d_e = rif.m0_wdata; end
        if (m_own == 1) begin we_e = rif.m1_we & rif.m1_req; a_e = rif.m1_addr; d_e = rif.m1_wdata; end
        check("m0_gnt",      rif.m0_gnt,      64'(m_own == 0));
        check("m1_gnt",      rif.m1_gnt,      64'(m_own == 1));
        check("busy",        rif.busy,        64'(m_own >= 0));
        check("owner",       rif.owner,       64'(m_own == 1));
        check("bus_we",      rif.bus_we,      64'(we_e));
        check("bus_addr",    rif.bus_addr,    64'(a_e));
        check("bus_wdata",   rif.bus_wdata,   64'(d_e));
        check("m0_rdata",    rif.m0_rdata,    64'(rif.bus_rdata));
        check("m1_rdata",    rif.m1_rdata,    64'(rif.bus_rdata));
        check("timeout_err", rif.timeout_err, 64'(m_terr));
    endtask

    // Advance one clock; model decides next owner from the arbitration rules
    task automatic adv();
        bit r[2], l[2];
        int nxt, hold_n, x, y;
        bit terr;
        r[0] = rif.m0_req; r[1] = rif.m1_req;
        l[0] = rif.m0_lock; l[1] = rif.m1_lock;
        nxt = m_own; hold_n = 0; terr = 0;
        if (m_own < 0) begin
            if (r[0] && r[1]) nxt = 1 - m_last;
            else if (r[0])    nxt = 0;
            else if (r[1])    nxt = 1;
        end else begin
            x = m_own; y = 1 - x;
            if (!r[x]) nxt = r[y] ? y : -1;
            else if (l[x]) begin
`ifdef RIB_ARB_TIMEOUT_EN
                if (r[y] && m_hold == MAXH - 1) begin
                    nxt = y; terr = 1;
                end else
                    hold_n = (m_hold + 1 > MAXH - 1) ? MAXH - 1 : m_hold + 1;
`endif
            end else if (r[y]) nxt = y;
        end
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else begin
            m_own = nxt;
            if (nxt >= 0) m_last = nxt;
            m_hold = hold_n;
            m_terr = terr;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int m0_cycles;
        bit seen_m1, seen_err;
        clear_inputs();

        // Reset state
        #2;
        settle();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset mid-transfer drops grant and write strobe immediately
        rif.m0_req = 1; rif.m0_we = 1; rif.m0_addr = 32'h2000_0000; rif.m0_wdata = 32'h1234_5678;
        settle(); adv();
        settle();
        check("t1_gnt_before", rif.m0_gnt, 1);
        check("t1_we_before",  rif.bus_we, 1);
        rst = 1'b1;
        model_reset();
        #1;
        check("t1_gnt_rst", rif.m0_gnt, 0);
        check("t1_we_rst",  rif.bus_we, 0);
        settle(); adv();
        rst = 1'b0;
        clear_inputs();
        settle();

        // Single write from master 0
        rif.m0_req = 1; rif.m0_we = 1; rif.m0_addr = 32'h1000_0004; rif.m0_wdata = 32'hDEAD_BEEF;
        settle();
        check("t2_no_gnt_yet", rif.m0_gnt, 0);
        adv(); settle();
        check("t2_gnt",   rif.m0_gnt,    1);
        check("t2_we",    rif.bus_we,    1);
        check("t2_addr",  rif.bus_addr,  32'h1000_0004);
        check("t2_wdata", rif.bus_wdata, 32'hDEAD_BEEF);
        adv();
        clear_inputs();
        settle(); adv(); settle();
        check("t2_idle_busy", rif.busy,     0);
        check("t2_idle_addr", rif.bus_addr, 0);

        // Strict alternation with both requesting, no lock
        do_reset();
        rif.m0_req = 1; rif.m0_addr = 32'h100; rif.m1_req = 1; rif.m1_addr = 32'h200;
        settle(); adv();
        for (int i = 0; i < 8; i++) begin
            settle();
            check("t3_alt_m0", rif.m0_gnt, 64'(i % 2 == 0));
            check("t3_alt_m1", rif.m1_gnt, 64'(i % 2 == 1));
            adv();
        end

        // Master 1 holds lock for 10 transfers while master 0 waits
        do_reset();
        rif.m1_req = 1; rif.m1_lock = 1; rif.m1_we = 1; rif.m1_addr = 32'h300; rif.m1_wdata = 32'h0000_1111;
        settle(); adv();
        rif.m0_req = 1; rif.m0_we = 1; rif.m0_addr = 32'h400; rif.m0_wdata = 32'hCAFE_F00D;
        for (int i = 0; i < 10; i++) begin
            settle();
`ifndef RIB_ARB_TIMEOUT_EN
            check("t4_lock_m1gnt", rif.m1_gnt,    1);
            check("t4_lock_wdata", rif.bus_wdata, 32'h0000_1111);
`endif
            rif.m1_wdata = 32'h0000_1111;
            adv();
        end
        rif.m1_lock = 0;
        settle(); adv();
        settle();
        check("t4_m0_after_unlock", rif.m0_gnt, 1);
        adv();

        // Lock timeout
        do_reset();
        rif.m0_req = 1; rif.m0_lock = 1; rif.m1_req = 1;
        settle(); adv();
        m0_cycles = 0; seen_m1 = 0; seen_err = 0;
`ifdef RIB_ARB_TIMEOUT_EN
        for (int i = 0; i < 20 && !seen_m1; i++) begin
            settle();
            if (rif.m1_gnt) begin
                seen_m1 = 1;
                check("t5_err_pulse", rif.timeout_err, 1);
            end else begin
                if (rif.m0_gnt) m0_cycles++;
                adv();
            end
        end
        check("t5_m1_granted", seen_m1, 1);
        check("t5_m0_cycles", m0_cycles, MAXH);
        adv(); settle();
        check("t5_err_one_cycle", rif.timeout_err, 0);
`else
        for (int i = 0; i < 100; i++) begin
            settle();
            if (rif.m1_gnt) seen_m1 = 1;
            if (rif.timeout_err) seen_err = 1;
            adv();
        end
        check("t5_m1_never", seen_m1, 0);
        check("t5_no_err",   seen_err, 0);
`endif

        // Read by master 1
        do_reset();
        rif.m1_req = 1; rif.m1_addr = 32'h0000_0040;
        settle(); adv();
        rif.bus_rdata = 32'h0000_00A5;
        settle();
        check("t6_m1_gnt",   rif.m1_gnt,   1);
        check("t6_m1_rdata", rif.m1_rdata, 32'h0000_00A5);
        check("t6_bus_we",   rif.bus_we,   0);
        adv();

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rif.m0_req   = ($urandom_range(9) < 7);
            rif.m0_lock  = ($urandom_range(9) < 3);
            rif.m0_we    = $urandom_range(1);
            rif.m0_addr  = $urandom;
            rif.m0_wdata = $urandom;
            rif.m1_req   = ($urandom_range(9) < 6);
            rif.m1_lock  = ($urandom_range(9) < 4);
            rif.m1_we    = $urandom_range(1);
            rif.m1_addr  = $urandom;
            rif.m1_wdata = $urandom;
            rif.bus_rdata = $urandom;
            settle();
            adv();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
